alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execute stage downstream of the ALU control decoder. It consumes the 4-bit ALUOperation code with operands A/B and a shift amount, and produces a registered result and Zero flag through a start/done handshake. Logic ops, ADD and LUI complete in one cycle. SLL/SRL use an iterative one-bit-per-cycle shifter unless the barrel option is compiled in.

## Interface
- DATA_WIDTH, 32: operand/result width; must be even, ≥ 2·16 for LUI.
- SHAMT_WIDTH, 5: shift-amount width; must equal log2(DATA_WIDTH).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on clk when unit is idle or done.
- ALUOperation  input  4  op code: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0101 LUI, 0110 SLL, 0111 SRL; all others illegal (incl. 1001).
- A  input  DATA_WIDTH  first operand (AND/OR/NOR/ADD).
- B  input  DATA_WIDTH  second operand; shifted operand for SLL/SRL; LUI source.
- shamt  input  SHAMT_WIDTH  shift amount.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse, result valid.
- ALUResult  output  DATA_WIDTH  registered result, held until next completion.
- Zero  output  1  registered (ALUResult == 0).
- illegal_op  output  1  pulses with done when op code was illegal.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset -> IDLE; busy=0, done=0, illegal_op=0, ALUResult=0, Zero=1.
- In IDLE or DONE with start=1: operands, op, shamt captured. Non-shift op or shamt=0 -> DONE. Shift with shamt≠0 -> SHIFT, counter=shamt, work register=B.
- DONE lasts one cycle, then IDLE unless start=1 (back-to-back accepted).
- SHIFT: each cycle the work register shifts 1 bit (SLL left, SRL right logical, zero fill); counter decrements. When counter reaches 0 -> DONE.
- Results: AND A&B; OR A|B; NOR ~(A|B); ADD A+B mod 2^DATA_WIDTH, carry/overflow discarded; LUI {B[15:0], zeros}; SLL B<<shamt; SRL B>>shamt.
- Illegal op: ALUResult=0, Zero=1, illegal_op=1 for the done cycle.
- ALUResult/Zero change only on entry to DONE; during SHIFT they hold the previous result.
- start while in SHIFT is ignored (no queueing). Inputs may change after capture without effect.
- Reset at any time, including mid-shift: abort, return to reset values, no done pulse.

## Timing
- start high in cycle 0 (accepted). Non-shift, illegal, or shamt=0: done/result in cycle 1; busy never asserts.
- Iterative shift, shamt=n>0: busy high cycles 1..n, done and result in cycle n+1. Worst case (n=31): done in cycle 32.
- done asserts exactly once per accepted start. busy and done are never high together.
- Max throughput: one non-shift op per cycle (start held high).

## Configuration
- ALU_EXEC_BARREL_EN defined: SLL/SRL computed combinationally by a barrel shifter on capture. All ops have 1-cycle latency. SHIFT state is unused and busy is tied 0.
- Undefined: iterative shifter as described; latency shamt+1.

## Test plan
- Reset then idle: ALUResult=0, Zero=1, busy=0, done=0. ADD A=0x7FFFFFFF B=1 -> cycle 1 done=1, ALUResult=0x80000000, Zero=0.
- ADD A=0xFFFFFFFF B=1 -> 0x00000000, Zero=1. NOR A=0 B=0 -> 0xFFFFFFFF. LUI B=0x00001234 -> 0x12340000. Issue these back-to-back with start held high -> one done per cycle.
- SLL B=1 shamt=31 -> busy cycles 1..31, done cycle 32, 0x80000000. SRL B=0x80000000 shamt=4 -> done cycle 5, 0x08000000. With ALU_EXEC_BARREL_EN -> both done cycle 1.
- ALUOperation=1001 or 1111 -> cycle 1 done=1, illegal_op=1, ALUResult=0, Zero=1.
- start pulse with AND during an SLL shamt=10 -> ignored; SLL completes cycle 11 with correct value; exactly one done.
- reset asserted in cycle 5 of SRL shamt=20 -> next cycle all outputs at reset values; no done; new ADD accepted afterwards.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle logic/ADD/LUI, iterative SLL/SRL.
// Define ALU_EXEC_BARREL_EN to compute shifts combinationally with 1-cycle latency.
module alu_exec_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   illegal_op,
  output logic [1:0]             dbg_state
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    left_q, left_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    illegal_q, illegal_d;

  logic [DATA_WIDTH-1:0]   op_result;
  logic                    op_illegal;
  logic                    op_is_shift;
  logic [DATA_WIDTH-1:0]   work_next;

  // Result of the captured op when it completes in the accept cycle.
  always_comb begin
    op_result   = '0;
    op_illegal  = 1'b0;
    op_is_shift = 1'b0;
    case (ALUOperation)
      OP_AND: op_result = A & B;
      OP_OR:  op_result = A | B;
      OP_NOR: op_result = ~(A | B);
      OP_ADD: op_result = A + B;
      OP_LUI: op_result = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_SLL: begin
        op_is_shift = 1'b1;
`ifdef ALU_EXEC_BARREL_EN
        op_result = B << shamt;
`else
        op_result = B;
`endif
      end
      OP_SRL: begin
        op_is_shift = 1'b1;
`ifdef ALU_EXEC_BARREL_EN
        op_result = B >> shamt;
`else
        op_result = B;
`endif
      end
      default: op_illegal = 1'b1;
    endcase
  end

  assign work_next = left_q ? (work_q << 1) : (work_q >> 1);

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
`ifdef ALU_EXEC_BARREL_EN
          state_d   = DONE;
          result_d  = op_result;
          zero_d    = (op_result == '0);
          illegal_d = op_illegal;
`else
          if (op_is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            work_d  = B;
            cnt_d   = shamt;
            left_d  = (ALUOperation == OP_SLL);
          end else begin
            state_d   = DONE;
            result_d  = op_result;
            zero_d    = (op_result == '0);
            illegal_d = op_illegal;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately ignored here; the shift runs to completion.
        work_d = work_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1}) begin
          state_d   = DONE;
          result_d  = work_next;
          zero_d    = (work_next == '0);
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake: a start seen in IDLE or DONE is accepted; done pulses for one
  // cycle per accepted start; busy covers the SHIFT cycles and never overlaps done.
  assign done       = (state_q == DONE);
`ifdef ALU_EXEC_BARREL_EN
  assign busy       = 1'b0;
`else
  assign busy       = (state_q == SHIFT);
`endif
  assign ALUResult  = result_q;
  assign Zero       = zero_q;
  assign illegal_op = done & illegal_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations queued at issue, checked on done.
module tb_alu_exec_unit;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int EW = DW + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    ALUOperation = 4'b0;
  logic [DW-1:0] A = '0;
  logic [DW-1:0] B = '0;
  logic [SW-1:0] shamt = '0;
  logic          busy, done, Zero, illegal_op;
  logic [DW-1:0] ALUResult;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int busy_cnt = 0;

  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];

  alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero), .illegal_op(illegal_op),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [SW-1:0] sh);
    logic [DW-1:0] r;
    logic          ill;
    r = '0;
    ill = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: r = a + b;
      4'd5: r = {b[15:0], 16'h0000};
      4'd6: r = b << sh;
      4'd7: r = b >> sh;
      default: ill = 1'b1;
    endcase
    return {ill, (r == '0), r};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [SW-1:0] sh);
`ifdef ALU_EXEC_BARREL_EN
    return 1;
`else
    if ((op == 4'd6 || op == 4'd7) && sh != '0) return int'(sh) + 1;
    return 1;
`endif
  endfunction

  // Driver: presents one op with start high for one edge; start stays high afterwards.
  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [SW-1:0] sh);
    ALUOperation = op; A = a; B = b; shamt = sh; start = 1'b1;
    exp_q.push_back(model(op, a, b, sh));
    cyc_q.push_back(cyc + latency(op, sh));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      check("busy_done_overlap", 64'(busy), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        logic [EW-1:0] e;
        int            c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("result", 64'({illegal_op, Zero, ALUResult}), 64'(e));
        check("done_cycle", 64'(cyc), 64'(c));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, 64'(ALUResult), 64'd0);
    check({tag, "_zero"}, 64'(Zero), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_illegal"}, 64'(illegal_op), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("rst");

    drive(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
    wait_idle();

    // Back-to-back single-cycle ops with start held high
    drive(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    drive(4'd2, 32'h0000_0000, 32'h0000_0000, 5'd0);
    drive(4'd5, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
    drive(4'd0, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 5'd0);
    drive(4'd1, 32'h0000_0000, 32'h0000_0000, 5'd0);
    wait_idle();

    busy_cnt = 0;
    drive(4'd6, 32'h0, 32'h0000_0001, 5'd31);
    wait_idle();
`ifdef ALU_EXEC_BARREL_EN
    check("busy_cycles_sll31", 64'(busy_cnt), 64'd0);
`else
    check("busy_cycles_sll31", 64'(busy_cnt), 64'd31);
`endif

    drive(4'd7, 32'h0, 32'h8000_0000, 5'd4);
    start = 1'b0;
`ifndef ALU_EXEC_BARREL_EN
    check("hold_during_shift", 64'(ALUResult), 64'h8000_0000);
`endif
    wait_idle();

    drive(4'd9, 32'h1234_5678, 32'h1, 5'd3);
    drive(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    drive(4'd4, 32'h5, 32'h5, 5'd0);
    drive(4'd6, 32'h0, 32'hA5A5_0001, 5'd0);
    wait_idle();

    // A stray start during a shift must not be queued
    drive(4'd6, 32'h0, 32'h0000_0003, 5'd10);
    start = 1'b0;
`ifndef ALU_EXEC_BARREL_EN
    repeat (2) begin @(posedge clk); #1; end
    ALUOperation = 4'd0; A = 32'hFFFF_FFFF; B = 32'h1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`endif
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end

    // Reset in cycle 5 of a long SRL aborts without a done pulse
    drive(4'd7, 32'h0, 32'hF000_0000, 5'd20);
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midshift_rst");
    exp_q.delete();
    cyc_q.delete();
    reset = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    drive(4'd3, 32'h0000_0010, 32'h0000_0020, 5'd0);
    wait_idle();

    // Random mix, including illegal codes and zero shift amounts
    for (int i = 0; i < 30; i++) begin
      logic [3:0]    op;
      logic [DW-1:0] ra, rb;
      logic [SW-1:0] rs;
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rs = 5'($urandom_range(0, 31));
      drive(op, ra, rb, rs);
      if ((op == 4'd6 || op == 4'd7) || $urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
